// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester and register-bank write signals shared by the write-port arbiter
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      locked;

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, locked
  );

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, locked
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin register-bank write-port arbiter with per-requester lock
// Optional REGFILE_ARB_CONFLICT_CNT_EN adds a saturating conflict_cnt_o counter.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  regfile_write_arbiter_if.slave    bus
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]               conflict_cnt_o
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;

  logic [NUM_REQ-1:0] ready;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic               xfer;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Grant selection: rotating search from rr_ptr in ARB, owner only in LOCKED.
  always_comb begin
    ready   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = rr_ptr_q;
    if (!rst_i) begin
      if (state_q == ST_LOCKED) begin
        gnt_idx = owner_q;
        found   = bus.req_valid[owner_q];
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && bus.req_valid[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
          end
          cand = next_ptr(cand);
        end
      end
    end
    if (found) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  assign xfer = found;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (xfer) begin
      if (bus.req_lock[gnt_idx]) begin
        state_d = ST_LOCKED;
        owner_d = gnt_idx;
      end else begin
        state_d  = ST_ARB;
        rr_ptr_d = next_ptr(gnt_idx);
      end
    end else if (state_q == ST_LOCKED && !bus.req_lock[owner_q]) begin
      // Idle owner dropped its lock: release and give the next requester priority.
      state_d  = ST_ARB;
      rr_ptr_d = next_ptr(owner_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wr_en_q  <= xfer;
      if (xfer) begin
        wr_addr_q <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
        wr_data_q <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.locked    = (state_q == ST_LOCKED);

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= '0;
    end else if ((|(bus.req_valid & ~ready)) && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - bench for regfile_write_arbiter: vector table, corner sequences, random vs model
module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  v, lk;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus_if)
`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt)
`endif
  );

  assign bus_if.req_valid = v;
  assign bus_if.req_lock  = lk;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus_if.req_addr[i*AW +: AW] = a[i];
      bus_if.req_data[i*DW +: DW] = d[i];
    end
  end

  // Reference: rotating priority list, owner = -1 when no lock is held.
  int            m_ptr   = 0;
  int            m_owner = -1;
  logic          m_en    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic [N-1:0]  dut_ready_s;
  logic [N-1:0]  last_rdy;

  function automatic logic [N-1:0] model_ready();
    if (rst) return '0;
    if (m_owner >= 0) return v[m_owner] ? (N'(1) << m_owner) : '0;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return N'(1) << ((m_ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic model_step(input logic [N-1:0] rdy);
    int g = -1;
    for (int i = 0; i < N; i++) if (rdy[i]) g = i;
    if (rst) begin
      m_en = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0; m_owner = -1;
    end else if (g >= 0) begin
      m_en = 1'b1; m_addr = a[g]; m_data = d[g];
      if (lk[g]) m_owner = g;
      else begin
        m_owner = -1;
        m_ptr   = (g + 1) % N;
      end
    end else begin
      m_en = 1'b0;
      if (m_owner >= 0 && !lk[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic run_cycle(input bit chk);
    logic [N-1:0] er;
    #3;
    er          = model_ready();
    dut_ready_s = bus_if.req_ready;
    last_rdy    = er;
    if (chk) check("ready", 32'(dut_ready_s), 32'(er));
    model_step(er);
    @(posedge clk);
    #1;
    if (chk) begin
      check("wr_en",   32'(bus_if.wr_en),   32'(m_en));
      check("wr_addr", 32'(bus_if.wr_addr), 32'(m_addr));
      check("wr_data", bus_if.wr_data,      m_data);
      check("locked",  32'(bus_if.locked),  32'(m_owner >= 0));
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  v;
    logic [N-1:0]  lk;
    logic [AW-1:0] a2;
    logic [N-1:0]  er;
    logic          en;
    logic [AW-1:0] ea;
    logic          el;
  } vec_t;

  vec_t tbl [21];
  logic [N-1:0] pend;

  initial begin
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'd3, 4'b0000, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 4'd3, 4'b0000, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b1111, 4'b0000, 4'd3, 4'b0001, 1'b1, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 4'd3, 4'b0010, 1'b1, 4'd2, 1'b0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 4'd3, 4'b0100, 1'b1, 4'd3, 1'b0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 4'd3, 4'b1000, 1'b1, 4'd4, 1'b0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0000, 4'd3, 4'b0001, 1'b1, 4'd1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0101, 4'b0100, 4'd5, 4'b0100, 1'b1, 4'd5, 1'b1};
    tbl[8]  = '{1'b0, 4'b0101, 4'b0100, 4'd6, 4'b0100, 1'b1, 4'd6, 1'b1};
    tbl[9]  = '{1'b0, 4'b0101, 4'b0000, 4'd7, 4'b0100, 1'b1, 4'd7, 1'b0};
    tbl[10] = '{1'b0, 4'b1001, 4'b0000, 4'd7, 4'b1000, 1'b1, 4'd4, 1'b0};
    tbl[11] = '{1'b0, 4'b0001, 4'b0000, 4'd7, 4'b0001, 1'b1, 4'd1, 1'b0};
    tbl[12] = '{1'b0, 4'b1000, 4'b1000, 4'd7, 4'b1000, 1'b1, 4'd4, 1'b1};
    tbl[13] = '{1'b0, 4'b0010, 4'b1000, 4'd7, 4'b0000, 1'b0, 4'd4, 1'b1};
    tbl[14] = '{1'b0, 4'b0010, 4'b1000, 4'd7, 4'b0000, 1'b0, 4'd4, 1'b1};
    tbl[15] = '{1'b0, 4'b0010, 4'b0000, 4'd7, 4'b0000, 1'b0, 4'd4, 1'b0};
    tbl[16] = '{1'b0, 4'b0010, 4'b0000, 4'd7, 4'b0010, 1'b1, 4'd2, 1'b0};
    tbl[17] = '{1'b0, 4'b0100, 4'b0100, 4'd9, 4'b0100, 1'b1, 4'd9, 1'b1};
    tbl[18] = '{1'b1, 4'b0101, 4'b0100, 4'd9, 4'b0000, 1'b0, 4'd0, 1'b0};
    tbl[19] = '{1'b0, 4'b0011, 4'b0000, 4'd9, 4'b0001, 1'b1, 4'd1, 1'b0};
    tbl[20] = '{1'b0, 4'b0000, 4'b0000, 4'd9, 4'b0000, 1'b0, 4'd1, 1'b0};

    for (int i = 0; i < N; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 32'hD000_0000 + DW'(i);
    end

    for (int r = 0; r < 21; r++) begin
      rst  = tbl[r].rst;
      v    = tbl[r].v;
      lk   = tbl[r].lk;
      a[2] = tbl[r].a2;
      run_cycle(1'b0);
      check($sformatf("row%0d_ready", r),  32'(dut_ready_s),    32'(tbl[r].er));
      check($sformatf("row%0d_wr_en", r),  32'(bus_if.wr_en),   32'(tbl[r].en));
      check($sformatf("row%0d_wr_addr", r), 32'(bus_if.wr_addr), 32'(tbl[r].ea));
      check($sformatf("row%0d_locked", r), 32'(bus_if.locked),  32'(tbl[r].el));
    end

    // Pointer wrap from the last requester back to 0, with full-width data.
    a[3] = 4'hF;
    d[3] = 32'hFFFF_FFFF;
    v = 4'b1000; lk = 4'b0000;
    run_cycle(1'b0);
    check("wrap_ready3", 32'(dut_ready_s), 32'h8);
    check("wrap_wr_data", bus_if.wr_data, 32'hFFFF_FFFF);
    check("wrap_wr_addr", 32'(bus_if.wr_addr), 32'hF);
    v = 4'b1010;
    run_cycle(1'b0);
    check("wrap_next_ready", 32'(dut_ready_s), 32'h2);
    v = 4'b0000;
    run_cycle(1'b0);

    // Randomised traffic against the reference model.
    rst = 1'b1; v = '0; lk = '0;
    run_cycle(1'b1);
    rst  = 1'b0;
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          a[i]    = AW'($urandom);
          d[i]    = $urandom;
          lk[i]   = ($urandom_range(0, 3) == 0);
        end else if (!pend[i]) begin
          lk[i] = 1'($urandom_range(0, 1));
        end
      end
      v = pend;
      run_cycle(1'b1);
      for (int i = 0; i < N; i++) if (last_rdy[i] && v[i]) pend[i] = 1'b0;
    end

`ifdef REGFILE_ARB_CONFLICT_CNT_EN
    rst = 1'b1; v = '0; lk = '0;
    run_cycle(1'b1);
    rst = 1'b0;
    check("conflict_reset", 32'(conflict_cnt), 32'd0);
    for (int c = 0; c < 10; c++) begin
      v = 4'b0011;
      run_cycle(1'b1);
    end
    check("conflict_10", 32'(conflict_cnt), 32'd10);
    force dut.conflict_q = 16'hFFFE;
    #1;
    release dut.conflict_q;
    for (int c = 0; c < 3; c++) begin
      v = 4'b0011;
      run_cycle(1'b1);
    end
    check("conflict_sat", 32'(conflict_cnt), 32'h0000_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
